// File: rtl/sys_mem_pkg.sv
// Shared types and helpers for the system-memory arbiter: agent ids,
// weight lists, FSM encoding and the round-robin requester search.
package sys_mem_pkg;

  localparam int NUM_AGENTS_DEF = 2;
  localparam int AGENT_ID_W     = (NUM_AGENTS_DEF > 1) ? $clog2(NUM_AGENTS_DEF) : 1;

  typedef logic [AGENT_ID_W-1:0] agent_id_t;
  typedef int weight_arr_t [NUM_AGENTS_DEF-1:0];

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic      found;
    agent_id_t id;
  } pick_t;

  function automatic int sum_weights(input weight_arr_t w);
    int s;
    s = 0;
    for (int i = 0; i < NUM_AGENTS_DEF; i++) s += w[i];
    return s;
  endfunction

  function automatic int max_weight(input weight_arr_t w);
    int m;
    m = w[0];
    for (int i = 1; i < NUM_AGENTS_DEF; i++) if (w[i] > m) m = w[i];
    return m;
  endfunction

  function automatic int min_weight(input weight_arr_t w);
    int m;
    m = w[0];
    for (int i = 1; i < NUM_AGENTS_DEF; i++) if (w[i] < m) m = w[i];
    return m;
  endfunction

  // Next agent id, wrapping at NUM_AGENTS_DEF.
  function automatic agent_id_t id_inc(input agent_id_t id);
    if (int'(id) == NUM_AGENTS_DEF - 1) return '0;
    return id + AGENT_ID_W'(1);
  endfunction

  // First requester at or after 'start' (wrapping); optionally skip 'excl'.
  function automatic pick_t next_req(input logic [NUM_AGENTS_DEF-1:0] req,
                                     input agent_id_t start,
                                     input logic excl_en,
                                     input agent_id_t excl);
    pick_t     p;
    agent_id_t idx;
    p   = '0;
    idx = start;
    for (int k = 0; k < NUM_AGENTS_DEF; k++) begin
      if (!p.found && req[idx] && !(excl_en && (idx == excl))) begin
        p.found = 1'b1;
        p.id    = idx;
      end
      idx = id_inc(idx);
    end
    return p;
  endfunction

endpackage

// File: rtl/sys_mem_rd_tag_fifo.sv
// Synchronous FIFO of agent ids for outstanding reads. Head is visible
// combinationally. A push while full is taken when a pop frees the slot
// in the same cycle.
module sys_mem_rd_tag_fifo
  import sys_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  agent_id_t din_i,
  output agent_id_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, rptr_q;
  agent_id_t   mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer registers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Tag storage, cleared on reset so the head never carries X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/sys_mem_arb.sv
// Weighted round-robin arbiter between system-memory agents and the single
// SDRAM controller port, with read-return routing through a tag FIFO.
//
// Handshake: an agent holds wren/rden (with addr/wdata) until a cycle in
// which its agent_wait is 0; that cycle is the transfer. Towards the
// controller, a request presented with cntrlr_wait=0 is taken that cycle.
// Read returns arrive in issue order, one per cntrlr_rd_valid cycle.
module sys_mem_arb
  import sys_mem_pkg::*;
#(
  parameter int          NUM_AGENTS       = 2,
  parameter int          MEM_DATA_W       = 32,
  parameter int          MEM_ADDR_W       = 27,
  parameter weight_arr_t ARB_WEIGHT_LIST  = '{8, 8},
  parameter int          ARB_TOTAL_WEIGHT = 16,
  parameter int          RD_TAG_DEPTH     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_AGENTS-1:0]                 agent_wren,
  input  logic [NUM_AGENTS-1:0]                 agent_rden,
  input  logic [NUM_AGENTS-1:0][MEM_ADDR_W-1:0] agent_addr,
  input  logic [NUM_AGENTS-1:0][MEM_DATA_W-1:0] agent_wdata,
  output logic [NUM_AGENTS-1:0]                 agent_wait,
  output logic [NUM_AGENTS-1:0]                 agent_rd_valid,
  output logic [NUM_AGENTS-1:0][MEM_DATA_W-1:0] agent_rdata,
  input  logic                                  cntrlr_wait,
  output logic                                  cntrlr_wren,
  output logic                                  cntrlr_rden,
  output logic [MEM_ADDR_W-1:0]                 cntrlr_addr,
  output logic [MEM_DATA_W-1:0]                 cntrlr_wdata,
  input  logic                                  cntrlr_rd_valid,
  input  logic [MEM_DATA_W-1:0]                 cntrlr_rdata,
  output logic                                  rd_err,
  output arb_state_e                            dbg_state,
  output agent_id_t                             dbg_gnt_id
);

  localparam int CREDIT_W = $clog2(max_weight(ARB_WEIGHT_LIST) + 1);
  typedef logic [CREDIT_W-1:0] credit_t;

  if (NUM_AGENTS != NUM_AGENTS_DEF) begin : g_chk_agents
    $error("sys_mem_arb: NUM_AGENTS must equal sys_mem_pkg::NUM_AGENTS_DEF");
  end
  if (sum_weights(ARB_WEIGHT_LIST) != ARB_TOTAL_WEIGHT) begin : g_chk_total
    $error("sys_mem_arb: ARB_TOTAL_WEIGHT does not match sum of ARB_WEIGHT_LIST");
  end
  if (min_weight(ARB_WEIGHT_LIST) < 1 || max_weight(ARB_WEIGHT_LIST) > 255) begin : g_chk_range
    $error("sys_mem_arb: each weight must be 1..255");
  end
  if (RD_TAG_DEPTH < 2 || (RD_TAG_DEPTH & (RD_TAG_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sys_mem_arb: RD_TAG_DEPTH must be a power of 2");
  end

  function automatic credit_t weight_of(input agent_id_t id);
    return credit_t'(ARB_WEIGHT_LIST[id]);
  endfunction

  arb_state_e state_q, state_d;
  agent_id_t  gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
  credit_t    credit_q, credit_d;
  logic       rd_err_q, rd_err_d;

  logic [NUM_AGENTS-1:0] req;
  logic      granted, gnt_wr, gnt_rd, rd_blocked, accept, hand_off;
  logic      fifo_full, fifo_empty, tag_push, tag_pop;
  agent_id_t tag_head;
  pick_t     idle_pick, handoff_pick;

  assign req        = agent_wren | agent_rden;
  assign granted    = (state_q == ARB_GRANT);
  // A simultaneous write and read from one agent is a write this beat.
  assign gnt_wr     = agent_wren[gnt_q];
  assign gnt_rd     = agent_rden[gnt_q] & ~gnt_wr;
  assign tag_pop    = cntrlr_rd_valid & ~fifo_empty;
  // A full tag FIFO only blocks reads when no return frees a slot this cycle.
  assign rd_blocked = fifo_full & ~tag_pop;
  assign accept     = granted & (gnt_wr | gnt_rd) & ~cntrlr_wait & ~(gnt_rd & rd_blocked);
  assign tag_push   = accept & gnt_rd;
  assign rd_err_d   = rd_err_q | (cntrlr_rd_valid & fifo_empty);

  assign rd_err     = rd_err_q;
  assign dbg_state  = state_q;
  assign dbg_gnt_id = gnt_q;

  sys_mem_rd_tag_fifo #(.DEPTH(RD_TAG_DEPTH)) u_rd_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .din_i   (gnt_q),
    .dout_o  (tag_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Zero-latency request mux towards the controller and per-agent responses.
  always_comb begin
    cntrlr_wren  = granted & gnt_wr;
    cntrlr_rden  = granted & gnt_rd & ~rd_blocked;
    cntrlr_addr  = agent_addr[gnt_q];
    cntrlr_wdata = agent_wdata[gnt_q];
    for (int i = 0; i < NUM_AGENTS; i++) begin
      agent_wait[i]     = ~(accept && (gnt_q == agent_id_t'(i)));
      agent_rd_valid[i] = tag_pop && (tag_head == agent_id_t'(i));
      agent_rdata[i]    = cntrlr_rdata;
    end
  end

  // Next-state: pick from IDLE, count credit while granted, hand off on release.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    credit_d     = credit_q;
    rr_ptr_d     = rr_ptr_q;
    hand_off     = 1'b0;
    idle_pick    = next_req(req, rr_ptr_q, 1'b0, '0);
    handoff_pick = next_req(req, id_inc(gnt_q), 1'b1, gnt_q);
    case (state_q)
      ARB_IDLE: begin
        if (idle_pick.found) begin
          state_d  = ARB_GRANT;
          gnt_d    = idle_pick.id;
          credit_d = weight_of(idle_pick.id);
        end
      end
      ARB_GRANT: begin
        if (accept) credit_d = credit_q - CREDIT_W'(1);
        hand_off = ~req[gnt_q] | (accept & (credit_q == CREDIT_W'(1)));
        if (hand_off) begin
          rr_ptr_d = id_inc(gnt_q);
          if (handoff_pick.found) begin
            gnt_d    = handoff_pick.id;
            credit_d = weight_of(handoff_pick.id);
          end else if (req[gnt_q]) begin
            credit_d = weight_of(gnt_q);
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state registers and the sticky read-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      credit_q <= '0;
      rr_ptr_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule
